// File: rtl/clk_test_window_seq.sv
// clk_test_window_seq: clk_test-domain measurement sequencer for the clock-rate
// monitor. It synchronises start/stop toggle requests from the clk_ref domain and
// counts clk_test cycles inside each window. The captured count is held behind a
// valid/ack handshake. It also tracks min/max over windows and counts dropped
// requests.
module clk_test_window_seq #(
  parameter int CNT_W   = 24,
  parameter int SYNC_FF = 2,
  parameter int MISS_W  = 8
) (
  input  logic              clk_test,
  input  logic              async_reset_clk_test,
  input  logic              start_tgl,
  input  logic              stop_tgl,
  input  logic              result_ack,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  min_cnt,
  output logic [CNT_W-1:0]  max_cnt,
  output logic [MISS_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [MISS_W:0]   MISS_MAX = {1'b0, {MISS_W{1'b1}}};

  // ---------------------------------------------------------------------------
  // Reset conditioning: assert asynchronously, release on a clk_test edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int;

  assign rst_sync_d = {rst_sync_q[0], 1'b0};
  assign rst_int    = rst_sync_q[1];

  // Two-flop release synchroniser for the incoming asynchronous reset.
  always_ff @(posedge clk_test or posedge async_reset_clk_test) begin
    if (async_reset_clk_test) rst_sync_q <= 2'b11;
    else                      rst_sync_q <= rst_sync_d;
  end

  // ---------------------------------------------------------------------------
  // Toggle synchronisers and edge detect.
  // ---------------------------------------------------------------------------
  logic [SYNC_FF-1:0] start_sync_q, start_sync_d;
  logic [SYNC_FF-1:0] stop_sync_q,  stop_sync_d;
  logic               start_edge_q, start_edge_d;
  logic               stop_edge_q,  stop_edge_d;
  logic               start_ev, stop_ev;

  assign start_sync_d = {start_sync_q[SYNC_FF-2:0], start_tgl};
  assign stop_sync_d  = {stop_sync_q[SYNC_FF-2:0],  stop_tgl};
  assign start_edge_d = start_sync_q[SYNC_FF-1];
  assign stop_edge_d  = stop_sync_q[SYNC_FF-1];
  // A request is any level change seen at the end of the chain.
  assign start_ev     = start_sync_q[SYNC_FF-1] ^ start_edge_q;
  assign stop_ev      = stop_sync_q[SYNC_FF-1]  ^ stop_edge_q;

  // Synchroniser chains and edge registers.
  // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_test or posedge rst_int) begin
    if (rst_int) begin
      start_sync_q <= '0;
      stop_sync_q  <= '0;
      start_edge_q <= 1'b0;
      stop_edge_q  <= 1'b0;
    end else begin
      start_sync_q <= start_sync_d;
      stop_sync_q  <= stop_sync_d;
      start_edge_q <= start_edge_d;
      stop_edge_q  <= stop_edge_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Window FSM.
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              capture;
  logic              ack_take;
  logic [1:0]        miss_inc;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, counter and per-edge event decode.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    ack_take = 1'b0;
    miss_inc = 2'd0;
    unique case (state_q)
      ST_IDLE: begin
        // Stop wins: a lone stop is a miss, and a start arriving with it is dropped too.
        if (stop_ev) begin
          miss_inc = start_ev ? 2'd2 : 2'd1;
        end else if (start_ev) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        cnt_d = cnt_inc;
        if (stop_ev) begin
          capture  = 1'b1;
          state_d  = ST_HOLD;
          miss_inc = {1'b0, start_ev};
        end else if (start_ev) begin
          cnt_d    = '0;
          miss_inc = 2'd1;
        end
      end
      ST_HOLD: begin
        miss_inc = {1'b0, start_ev & ~result_ack} + {1'b0, stop_ev};
        if (result_ack) begin
          ack_take = 1'b1;
          if (start_ev) begin
            state_d = ST_COUNT;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result, statistics and miss counter.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  result_q, result_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  min_q, min_d, min_base;
  logic [CNT_W-1:0]  max_q, max_d, max_base;
  logic [MISS_W-1:0] miss_q, miss_d, miss_base;
  logic [MISS_W:0]   miss_sum;

  // Capture/handshake and statistics update; clear_stats acts before a same-edge capture or miss.
  always_comb begin
    result_d  = result_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    min_base  = clear_stats ? CNT_MAX : min_q;
    max_base  = clear_stats ? '0 : max_q;
    min_d     = min_base;
    max_d     = max_base;
    miss_base = clear_stats ? '0 : miss_q;
    miss_sum  = {1'b0, miss_base} + (MISS_W + 1)'(miss_inc);
    miss_d    = (miss_sum > MISS_MAX) ? MISS_MAX[MISS_W-1:0] : miss_sum[MISS_W-1:0];
    if (capture) begin
      result_d = cnt_q;
      valid_d  = 1'b1;
      ovf_d    = (cnt_q == CNT_MAX);
      min_d    = (cnt_q < min_base) ? cnt_q : min_base;
      max_d    = (cnt_q > max_base) ? cnt_q : max_base;
    end else if (ack_take) begin
      valid_d  = 1'b0;
    end
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk_test or posedge rst_int) begin
    if (rst_int) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      min_q    <= CNT_MAX;
      max_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      min_q    <= min_d;
      max_q    <= max_d;
      miss_q   <= miss_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = (state_q == ST_COUNT);
  assign overflow     = ovf_q;
  assign min_cnt      = min_q;
  assign max_cnt      = max_q;
  assign miss_cnt     = miss_q;

endmodule

// File: tb/tb_clk_test_window_seq.sv
// Directed bench for clk_test_window_seq: a default-width instance plus an
// 8-bit-counter instance sharing the same stimulus.
module tb_clk_test_window_seq;

  logic        clk_test = 1'b0;
  logic        async_reset_clk_test = 1'b1;
  logic        start_tgl = 1'b0;
  logic        stop_tgl = 1'b0;
  logic        result_ack = 1'b0;
  logic        clear_stats = 1'b0;

  logic [23:0] result, min_cnt, max_cnt;
  logic        result_valid, busy, overflow;
  logic [7:0]  miss_cnt;

  logic [7:0]  r8_result, r8_min, r8_max, r8_miss;
  logic        r8_valid, r8_busy, r8_overflow;

  int passed = 0;
  int total  = 0;

  clk_test_window_seq dut (
    .clk_test(clk_test), .async_reset_clk_test(async_reset_clk_test),
    .start_tgl(start_tgl), .stop_tgl(stop_tgl), .result_ack(result_ack),
    .clear_stats(clear_stats), .result(result), .result_valid(result_valid),
    .busy(busy), .overflow(overflow), .min_cnt(min_cnt), .max_cnt(max_cnt),
    .miss_cnt(miss_cnt)
  );

  clk_test_window_seq #(.CNT_W(8)) dut8 (
    .clk_test(clk_test), .async_reset_clk_test(async_reset_clk_test),
    .start_tgl(start_tgl), .stop_tgl(stop_tgl), .result_ack(result_ack),
    .clear_stats(clear_stats), .result(r8_result), .result_valid(r8_valid),
    .busy(r8_busy), .overflow(r8_overflow), .min_cnt(r8_min), .max_cnt(r8_max),
    .miss_cnt(r8_miss)
  );

  always #5 clk_test = ~clk_test;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Inputs change just after a falling edge; outputs are sampled there too.
  task automatic tick(input int n);
    repeat (n) @(negedge clk_test);
  endtask

  task automatic do_reset();
    async_reset_clk_test = 1'b1;
    start_tgl = 1'b0; stop_tgl = 1'b0; result_ack = 1'b0; clear_stats = 1'b0;
    tick(2);
    async_reset_clk_test = 1'b0;
    tick(4);
  endtask

  // Stop toggled n+1 cycles after start, so the stop event sees cnt == n.
  task automatic run_window(input int n);
    start_tgl = ~start_tgl;
    tick(n + 1);
    stop_tgl = ~stop_tgl;
    tick(3);
  endtask

  task automatic ack();
    result_ack = 1'b1;
    tick(1);
    result_ack = 1'b0;
  endtask

  initial begin
    tick(1);
    do_reset();

    // Reset state
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_min", min_cnt, 24'hFFFFFF);
    check("rst_max", max_cnt, 0);
    check("rst_miss", miss_cnt, 0);

    // 1: 1000-cycle window
    run_window(1000);
    check("t1_result", result, 1000);
    check("t1_valid", result_valid, 1);
    check("t1_min", min_cnt, 1000);
    check("t1_max", max_cnt, 1000);
    check("t1_ovf", overflow, 0);
    check("t1_miss", miss_cnt, 0);
    check("t1_busy", busy, 0);

    // 2: two starts dropped in HOLD, then ack back to IDLE
    start_tgl = ~start_tgl; tick(4);
    start_tgl = ~start_tgl; tick(4);
    check("t2_miss", miss_cnt, 2);
    check("t2_result", result, 1000);
    check("t2_valid", result_valid, 1);
    ack();
    check("t2_valid_ack", result_valid, 0);
    check("t2_busy_ack", busy, 0);

    // 3: saturation on the 8-bit instance
    do_reset();
    run_window(300);
    check("t3_r8_result", r8_result, 255);
    check("t3_r8_ovf", r8_overflow, 1);
    check("t3_result", result, 300);
    check("t3_ovf", overflow, 0);
    ack();
    run_window(10);
    check("t3_r8_result2", r8_result, 10);
    check("t3_r8_ovf2", r8_overflow, 0);
    check("t3_r8_min", r8_min, 10);
    check("t3_r8_max", r8_max, 255);
    check("t3_min", min_cnt, 10);
    check("t3_max", max_cnt, 300);
    ack();

    // 4: start+stop together at cnt 50, then ack+start together
    start_tgl = ~start_tgl;
    tick(51);
    start_tgl = ~start_tgl; stop_tgl = ~stop_tgl;
    tick(3);
    check("t4_result", result, 50);
    check("t4_miss", miss_cnt, 1);
    check("t4_valid", result_valid, 1);
    check("t4_busy_hold", busy, 0);
    start_tgl = ~start_tgl;
    tick(2);
    ack();
    check("t4_busy", busy, 1);
    check("t4_valid_ack", result_valid, 0);

    // 5: reset mid-window at cnt 500
    tick(500);
    check("t5_busy_pre", busy, 1);
    async_reset_clk_test = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_valid", result_valid, 0);
    check("t5_result", result, 0);
    check("t5_miss", miss_cnt, 0);
    check("t5_min", min_cnt, 24'hFFFFFF);
    check("t5_max", max_cnt, 0);
    check("t5_ovf", overflow, 0);
    start_tgl = 1'b0; stop_tgl = 1'b0;
    tick(2);
    async_reset_clk_test = 1'b0;
    tick(4);
    stop_tgl = ~stop_tgl;
    tick(3);
    check("t5_miss_stop", miss_cnt, 1);
    check("t5_valid_stop", result_valid, 0);
    check("t5_result_stop", result, 0);

    // 6: clear_stats coincident with a capture and with a miss
    run_window(900);
    check("t6_max900", max_cnt, 900);
    ack();
    start_tgl = ~start_tgl;
    tick(78);
    stop_tgl = ~stop_tgl;
    tick(2);
    clear_stats = 1'b1; tick(1); clear_stats = 1'b0;
    check("t6_result", result, 77);
    check("t6_min", min_cnt, 77);
    check("t6_max", max_cnt, 77);
    check("t6_miss_clr", miss_cnt, 0);
    ack();
    stop_tgl = ~stop_tgl; tick(3);
    check("t6_miss_pre", miss_cnt, 1);
    stop_tgl = ~stop_tgl;
    tick(2);
    clear_stats = 1'b1; tick(1); clear_stats = 1'b0;
    check("t6_miss", miss_cnt, 1);
    check("t6_min_clr", min_cnt, 24'hFFFFFF);
    check("t6_max_clr", max_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
